// File: rtl/iq_imb_estimator.sv
// iq_imb_estimator
// Block statistics for I/Q mismatch estimation. Accumulates I*I, Q*Q and I*Q
// over 2^LOG2_N accepted Q1.15 samples and publishes the block means in Q2.30.
// Optional DC (mean I / mean Q) estimation is enabled by defining IQ_DC_EST_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; accumulators hold the last block
// S_ACCUM | accepting samples whenever in_valid is high
// S_FLUSH | last product drains from the product stage into the sums
// S_DONE  | results are published and est_valid pulses on the next edge
module iq_imb_estimator #(
   parameter int LOG2_N = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [15:0] i_in,
   input  logic [15:0] q_in,
   output logic        busy,
   output logic        est_valid,
   output logic [31:0] pwr_i,
   output logic [31:0] pwr_q,
   output logic [31:0] cross_iq
`ifdef IQ_DC_EST_EN
   ,
   output logic [15:0] dc_i,
   output logic [15:0] dc_q
`endif
);

   localparam int AW = 32 + LOG2_N;
   localparam logic [LOG2_N-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [LOG2_N-1:0] cnt;
   logic              accept;
   logic              acc_clr;
   logic              publish;

   logic signed [15:0] i_s, q_s;
   logic signed [31:0] prod_ii, prod_qq, prod_iq;
   logic               prod_vld;
   logic signed [AW-1:0] acc_ii, acc_qq, acc_iq;

   assign i_s    = i_in;
   assign q_s    = q_in;
   assign accept = (state == S_ACCUM) && in_valid;
   assign busy   = (state != S_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; start while busy simply falls through to the default
   always_comb begin
      state_nxt = state;
      acc_clr   = 1'b0;
      publish   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ACCUM;
               acc_clr   = 1'b1;
            end
         end
         S_ACCUM: begin
            if (accept && (cnt == CNT_LAST)) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_DONE;
         S_DONE: begin
            publish   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Accepted-sample counter; wraps to zero on the final sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (acc_clr) cnt <= '0;
      else if (accept)  cnt <= cnt + 1'b1;
   end

   // Product stage: registered full-precision 16x16 signed products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_ii  <= '0;
         prod_qq  <= '0;
         prod_iq  <= '0;
         prod_vld <= 1'b0;
      end else begin
         prod_ii  <= i_s * i_s;
         prod_qq  <= q_s * q_s;
         prod_iq  <= i_s * q_s;
         prod_vld <= accept;
      end
   end

   // Accumulate stage: LOG2_N guard bits make overflow impossible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_ii <= '0;
         acc_qq <= '0;
         acc_iq <= '0;
      end else if (acc_clr) begin
         acc_ii <= '0;
         acc_qq <= '0;
         acc_iq <= '0;
      end else if (prod_vld) begin
         acc_ii <= acc_ii + AW'(prod_ii);
         acc_qq <= acc_qq + AW'(prod_qq);
         acc_iq <= acc_iq + AW'(prod_iq);
      end
   end

   // Result registers: mean = sum >>> LOG2_N, which always fits in Q2.30
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         est_valid <= 1'b0;
         pwr_i     <= '0;
         pwr_q     <= '0;
         cross_iq  <= '0;
      end else begin
         est_valid <= publish;
         if (publish) begin
            pwr_i    <= 32'(acc_ii >>> LOG2_N);
            pwr_q    <= 32'(acc_qq >>> LOG2_N);
            cross_iq <= 32'(acc_iq >>> LOG2_N);
         end
      end
   end

`ifdef IQ_DC_EST_EN
   localparam int DW = 16 + LOG2_N;

   logic signed [15:0]   i_d, q_d;
   logic signed [DW-1:0] acc_di, acc_dq;

   // DC sample delay, aligned with the product stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_d <= '0;
         q_d <= '0;
      end else begin
         i_d <= i_s;
         q_d <= q_s;
      end
   end

   // DC sums share the product-stage valid and the block clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_di <= '0;
         acc_dq <= '0;
      end else if (acc_clr) begin
         acc_di <= '0;
         acc_dq <= '0;
      end else if (prod_vld) begin
         acc_di <= acc_di + DW'(i_d);
         acc_dq <= acc_dq + DW'(q_d);
      end
   end

   // DC results publish together with the power results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc_i <= '0;
         dc_q <= '0;
      end else if (publish) begin
         dc_i <= 16'(acc_di >>> LOG2_N);
         dc_q <= 16'(acc_dq >>> LOG2_N);
      end
   end
`endif

endmodule

// File: tb/tb_iq_imb_estimator.sv
// Testbench for iq_imb_estimator (LOG2_N = 4). Reference model sums the
// accepted samples with 64-bit integer arithmetic and divides by 16.
module tb_iq_imb_estimator;

   localparam int L = 4;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] i_in = '0;
   logic [15:0] q_in = '0;
   logic        busy, est_valid;
   logic [31:0] pwr_i, pwr_q, cross_iq;
`ifdef IQ_DC_EST_EN
   logic [15:0] dc_i, dc_q;
`endif

   iq_imb_estimator #(.LOG2_N(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .i_in      (i_in),
      .q_in      (q_in),
      .busy      (busy),
      .est_valid (est_valid),
      .pwr_i     (pwr_i),
      .pwr_q     (pwr_q),
      .cross_iq  (cross_iq)
`ifdef IQ_DC_EST_EN
      ,
      .dc_i      (dc_i),
      .dc_q      (dc_q)
`endif
   );

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   longint s_ii, s_qq, s_iq, s_i, s_q;
   logic [31:0] e_pi, e_pq, e_iq;
   logic [15:0] e_di, e_dq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntests++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic gen_sample(input int mode, input int idx, output logic [15:0] i, output logic [15:0] q);
      logic [31:0] r;
      r = $urandom;
      case (mode)
         1: begin i = 16'd16384; q = 16'd8192; end
         2: begin i = 16'h8000;  q = 16'h8000; end
         3: begin i = 16'd16384; q = (idx % 2 == 0) ? 16'h4000 : 16'hC000; end
         4: begin i = 16'd0;     q = r[15:0]; end
         default: begin i = r[15:0]; q = r[31:16]; end
      endcase
   endtask

   task automatic model_add(input logic [15:0] i, input logic [15:0] q);
      longint li, lq;
      li = longint'($signed(i));
      lq = longint'($signed(q));
      s_ii += li * li;
      s_qq += lq * lq;
      s_iq += li * lq;
      s_i  += li;
      s_q  += lq;
   endtask

   task automatic model_mean();
      longint m;
      m = s_ii >>> L; e_pi = m[31:0];
      m = s_qq >>> L; e_pq = m[31:0];
      m = s_iq >>> L; e_iq = m[31:0];
      m = s_i  >>> L; e_di = m[15:0];
      m = s_q  >>> L; e_dq = m[15:0];
   endtask

   task automatic chk_results(input string tag);
      chk({tag, " pwr_i"},    pwr_i,    e_pi);
      chk({tag, " pwr_q"},    pwr_q,    e_pq);
      chk({tag, " cross_iq"}, cross_iq, e_iq);
`ifdef IQ_DC_EST_EN
      chk({tag, " dc_i"}, {16'd0, dc_i}, {16'd0, e_di});
      chk({tag, " dc_q"}, {16'd0, dc_q}, {16'd0, e_dq});
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},      {31'd0, busy},      32'd0);
      chk({tag, " est_valid"}, {31'd0, est_valid}, 32'd0);
      chk({tag, " pwr_i"},     pwr_i,    32'd0);
      chk({tag, " pwr_q"},     pwr_q,    32'd0);
      chk({tag, " cross_iq"},  cross_iq, 32'd0);
`ifdef IQ_DC_EST_EN
      chk({tag, " dc_i"}, {16'd0, dc_i}, 32'd0);
      chk({tag, " dc_q"}, {16'd0, dc_q}, 32'd0);
`endif
   endtask

   // Runs one block: start, accumulate N accepted samples, then check the
   // est_valid timing (2 edges after the last sample) and the published means.
   task automatic run_block(input int mode, input int gap, input bit start_with_sample,
                            input bit mid_start, input string tag);
      int acc;
      int cyc;
      logic v;
      logic [15:0] si, sq;
      logic [31:0] r;
      s_ii = 0; s_qq = 0; s_iq = 0; s_i = 0; s_q = 0;
      @(negedge clk);
      chk({tag, " busy before start"}, {31'd0, busy}, 32'd0);
      start = 1'b1;
      if (start_with_sample) begin
         in_valid = 1'b1;
         i_in = 16'h7FFF;
         r = $urandom;
         q_in = r[15:0];
      end else begin
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " busy rise"}, {31'd0, busy}, 32'd1);
      acc = 0;
      cyc = 0;
      while (acc < N) begin
         @(negedge clk);
         start = mid_start && (cyc == 5 || cyc == 6);
         if (gap == 0 || cyc > 200) v = 1'b1;
         else if (gap == 1)         v = (cyc % 2 == 0);
         else                       v = 1'($urandom_range(0, 1));
         gen_sample(mode, acc, si, sq);
         in_valid = v;
         i_in = si;
         q_in = sq;
         @(posedge clk); #1;
         if (v) begin
            acc++;
            model_add(si, sq);
         end
         cyc++;
         if (cyc == 4) chk({tag, " no early est_valid"}, {31'd0, est_valid}, 32'd0);
      end
      model_mean();
      // edge k+1 (FLUSH): inputs here must be ignored
      @(negedge clk);
      start = 1'b0;
      r = $urandom;
      in_valid = r[0];
      i_in = r[31:16];
      q_in = r[15:0];
      @(posedge clk); #1;
      chk({tag, " est_valid k+1"}, {31'd0, est_valid}, 32'd0);
      chk({tag, " busy k+1"},      {31'd0, busy},      32'd1);
      // edge k+2 (publish)
      @(negedge clk);
      r = $urandom;
      in_valid = r[0];
      i_in = r[31:16];
      q_in = r[15:0];
      @(posedge clk); #1;
      chk({tag, " est_valid k+2"}, {31'd0, est_valid}, 32'd1);
      chk({tag, " busy k+2"},      {31'd0, busy},      32'd0);
      chk_results(tag);
      // edge k+3: pulse ends, results hold
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, " est_valid k+3"}, {31'd0, est_valid}, 32'd0);
      chk({tag, " hold pwr_i"}, pwr_i, e_pi);
      chk({tag, " hold cross_iq"}, cross_iq, e_iq);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_block(1, 0, 1'b0, 1'b0, "const");
      chk("const pwr_i abs",    pwr_i,    32'd268435456);
      chk("const pwr_q abs",    pwr_q,    32'd67108864);
      chk("const cross_iq abs", cross_iq, 32'd134217728);

      run_block(2, 0, 1'b0, 1'b0, "fullscale");
      chk("fullscale pwr_i abs",    pwr_i,    32'd1073741824);
      chk("fullscale cross_iq abs", cross_iq, 32'd1073741824);

      run_block(3, 0, 1'b0, 1'b0, "alt_q");
      chk("alt_q cross_iq abs", cross_iq, 32'd0);
      chk("alt_q pwr_q abs",    pwr_q,    32'd268435456);

      run_block(1, 1, 1'b0, 1'b1, "gaps");
      chk("gaps pwr_i abs",    pwr_i,    32'd268435456);
      chk("gaps cross_iq abs", cross_iq, 32'd134217728);
      repeat (6) begin
         @(posedge clk); #1;
         chk("gaps single est_valid", {31'd0, est_valid}, 32'd0);
      end

      run_block(4, 0, 1'b1, 1'b0, "start_sample");
      chk("start_sample pwr_i abs", pwr_i, 32'd0);

      // Reset in the middle of a block
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         r = $urandom;
         in_valid = 1'b1;
         i_in = r[15:0];
         q_in = r[31:16];
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 24; k++) begin
         r = $urandom;
         in_valid = r[0];
         i_in = r[31:16];
         @(posedge clk); #1;
         if (k == 23) chk("midreset busy after", {31'd0, busy}, 32'd0);
         if (k % 6 == 0) chk("midreset no est_valid", {31'd0, est_valid}, 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;

      run_block(0, 0, 1'b0, 1'b0, "post_reset");
      for (int b = 0; b < 6; b++) begin
         run_block(0, 2, 1'(b % 2), 1'(b % 3 == 0), $sformatf("rand%0d", b));
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/iq_imb_estimator.md
# iq_imb_estimator

Block-statistics estimator placed directly downstream of the I/Q mismatch stage. It consumes the impaired Q1.15 I/Q stream and accumulates I², Q² and I·Q over a block of 2^LOG2_N accepted samples. It then publishes the block means, from which firmware derives gain and phase correction coefficients. It runs one block per `start` request.

## Interface
Parameters:
- `LOG2_N`, default 10: log2 of the block length in samples; legal range 2–16.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: pulse that requests a new estimation block.
- `in_valid`, in, 1: the sample on `i_in`/`q_in` is valid this cycle.
- `i_in`, in, 16: signed Q1.15 I sample.
- `q_in`, in, 16: signed Q1.15 Q sample.
- `busy`, out, 1: high from the accepted `start` until `est_valid`.
- `est_valid`, out, 1: one-cycle pulse; the result registers are updated in the same cycle.
- `pwr_i`, out, 32: mean of I², signed Q2.30.
- `pwr_q`, out, 32: mean of Q², signed Q2.30.
- `cross_iq`, out, 32: mean of I·Q, signed Q2.30.
- `dc_i`, out, 16: mean of I, Q1.15. Present only with `IQ_DC_EST_EN`.
- `dc_q`, out, 16: mean of Q, Q1.15. Present only with `IQ_DC_EST_EN`.

## Operation
- FSM states: IDLE, ACCUM, FLUSH, DONE.
  - IDLE → ACCUM on `start`. Accumulators and the sample counter are cleared in that same cycle.
  - ACCUM: every cycle with `in_valid` high, the sample is accepted and the counter increments. When the counter reaches 2^LOG2_N−1 and another sample is accepted, go to FLUSH.
  - FLUSH: one cycle to drain the product pipeline into the accumulators. Then go to DONE.
  - DONE: publish the results, pulse `est_valid`, and return to IDLE.
- Product stage (pipeline stage 1): registered 16×16 signed products I·I, Q·Q, I·Q, each 32 bits wide, plus a registered valid bit.
- Accumulate stage (pipeline stage 2): signed accumulators of width 32+LOG2_N. They cannot overflow.
  - Full-scale case: (−32768)² = 2^30 per sample.
- Mean: arithmetic shift right by LOG2_N, keeping the low 32 bits. The mean is bounded in magnitude by 2^30, so no saturation is required.
- `in_valid` outside ACCUM is ignored; no sample is counted.
- `start` while `busy` is ignored; the current block continues.
- `start` and `in_valid` in the same cycle in IDLE: that sample is not counted. Counting begins the following cycle.
- `in_valid` gaps during ACCUM stall counting only. Gaps have no other effect.
- Samples are never dropped during ACCUM. The block has no backpressure.

## Timing
- Reset values: `busy`=0, `est_valid`=0, all result outputs = 0, FSM = IDLE, accumulators and counter = 0.
- `busy` rises in the cycle after `start` is sampled.
- Latency: with the last (2^LOG2_N-th) sample accepted at edge k, FLUSH is at k+1, DONE at k+2, and `est_valid` is high during cycle k+2 to k+3.
  - Results change only on the `est_valid` edge. They hold until the next `est_valid` or reset.
- `busy` falls together with the `est_valid` pulse.
- A new `start` is accepted in the cycle immediately after `est_valid`.
- Minimum block duration from `start` to `est_valid` is 2^LOG2_N+3 cycles.
- `rst_n` asserted mid-block: the block aborts immediately, all state and outputs return to reset values, and no `est_valid` is produced.

## Configuration
- Macro `IQ_DC_EST_EN`.
- Defined:
  - Two extra 16+LOG2_N-bit signed accumulators sum `i_in` and `q_in` through the same pipeline.
  - `dc_i` and `dc_q` equal the sums shifted right arithmetically by LOG2_N. They are published and reset exactly like the other results.
- Undefined:
  - The `dc_i`/`dc_q` ports and their accumulators are absent.
  - All other behaviour and timing are identical.

## Test plan
- LOG2_N=4; `start`; 16 samples with I=16384, Q=8192, `in_valid` continuous → `est_valid` exactly 2 cycles after the 16th sample, with `pwr_i`=268435456, `pwr_q`=67108864, `cross_iq`=134217728. With the macro: `dc_i`=16384, `dc_q`=8192.
- Full scale: I=Q=−32768 for 16 samples → `pwr_i`=`pwr_q`=`cross_iq`=1073741824. No wrap occurs. `dc_i`=−32768.
- I=16384, Q alternating +16384/−16384 → `cross_iq`=0, `pwr_q`=268435456. With the macro: `dc_q`=0.
- `in_valid` toggling 1-0-1-0 for 16 accepted samples, plus a `start` pulse mid-block → one `est_valid` only, results unchanged from the continuous case. `start` is ignored while `busy`.
- `start` and `in_valid` in the same cycle with I=32767, followed by 16 samples of I=0 → `pwr_i`=0; the first sample is not counted.
- `rst_n` low after 8 of 16 samples → all outputs 0 and `busy`=0 immediately. No `est_valid` follows. A fresh block afterwards produces correct values.
